// File: rtl/nco_tdm_pm.sv
// Time-multiplexed NCO: one accumulator adder and one quarter-wave sine LUT shared
// round-robin over NCH channels, with per-channel increment, phase offset and sync.
module nco_tdm_pm #(
  parameter int APR = 32,
  parameter int MPR = 14,
  parameter int RAW = 10,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int PMW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_sel,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic [APR-1:0]        cfg_data,
  output logic signed [MPR-1:0] fsin_o,
  output logic signed [MPR-1:0] fcos_o,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_valid
);

  localparam int LW = MPR - 1;
  localparam int LN = 2 ** RAW;
  localparam int HW = RAW + 2;
  localparam int LB = PMW - HW;

  // Elaboration-time sine for LUT entry k (Taylor series, rounded to nearest).
  function automatic logic [LW-1:0] lut_entry(input int k);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LN);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return LW'($rtoi(sum * real'((2 ** LW) - 1) + 0.5));
  endfunction

  logic [LW-1:0] lut_s [LN];
  for (genvar k = 0; k < LN; k++) begin : g_lut
    localparam logic [LW-1:0] LV = lut_entry(k);
    assign lut_s[k] = LV;
  end

  logic [APR-1:0] acc_r [NCH];
  logic [APR-1:0] inc_r [NCH];
  logic [PMW-1:0] off_r [NCH];
  logic [NCH-1:0] sync_pend_r, sync_pend_s;
  logic [CHW-1:0] ch_cnt_r;
  logic           cfg_ready_r;
  logic           cfg_xfer_s, slot_sync_s, carry_s;
  logic [PMW-1:0] ph_top_s, off_s;
  logic [HW-1:0]  p_hi_s;
  logic [RAW-1:0] addr_s;

  logic           s1_v_r, s2_v_r, s3_v_r;
  logic [CHW-1:0] s1_ch_r, s2_ch_r, s3_ch_r;
  logic [1:0]     s1_quad_r, s2_quad_r;
  logic [RAW-1:0] s1_addr_r;
  logic [LW-1:0]  s2_ls_r, s2_lc_r;
  logic signed [MPR-1:0] s3_sin_r, s3_cos_r, ls_ext_s, lc_ext_s;

  assign cfg_ready  = cfg_ready_r;
  assign cfg_xfer_s = cfg_valid & cfg_ready_r;
  assign ls_ext_s   = {1'b0, s2_ls_r};
  assign lc_ext_s   = {1'b0, s2_lc_r};

  // Slot phase and S1 address; only the phase MSBs matter, so the low part contributes a carry.
  always_comb begin
    slot_sync_s = sync_pend_r[ch_cnt_r];
    off_s       = off_r[ch_cnt_r];
    if (slot_sync_s) begin
      ph_top_s = '0;
    end else begin
      ph_top_s = acc_r[ch_cnt_r][APR-1 -: PMW];
    end
    carry_s = (ph_top_s[LB-1:0] > ~off_s[LB-1:0]);
    p_hi_s  = ph_top_s[PMW-1 -: HW] + off_s[PMW-1 -: HW] + {{(HW-1){1'b0}}, carry_s};
    if (p_hi_s[HW-2]) begin
      addr_s = ~p_hi_s[RAW-1:0];
    end else begin
      addr_s = p_hi_s[RAW-1:0];
    end
  end

  // Pending syncs: consumed by their channel's slot, set by an accepted sync request afterwards.
  always_comb begin
    sync_pend_s = sync_pend_r;
    if (clken && slot_sync_s) begin
      sync_pend_s[ch_cnt_r] = 1'b0;
    end else begin
      sync_pend_s = sync_pend_r;
    end
    if (cfg_xfer_s && (cfg_sel == 2'd2)) begin
      sync_pend_s[cfg_ch] = 1'b1;
    end else begin
      sync_pend_s = sync_pend_s;
    end
  end

  // Configuration registers and sync bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        inc_r[i] <= '0;
        off_r[i] <= '0;
      end
      sync_pend_r <= '0;
      cfg_ready_r <= 1'b1;
    end else begin
      if (cfg_xfer_s) begin
        case (cfg_sel)
          2'd0:    inc_r[cfg_ch] <= cfg_data;
          2'd1:    off_r[cfg_ch] <= cfg_data[PMW-1:0];
          default: ;
        endcase
      end
      sync_pend_r <= sync_pend_s;
      cfg_ready_r <= ~(|sync_pend_s);
    end
  end

  // Channel counter and shared accumulator update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= '0;
      end
      ch_cnt_r <= '0;
    end else if (clken) begin
      if (slot_sync_s) begin
        acc_r[ch_cnt_r] <= inc_r[ch_cnt_r];
      end else begin
        acc_r[ch_cnt_r] <= acc_r[ch_cnt_r] + inc_r[ch_cnt_r];
      end
      ch_cnt_r <= ch_cnt_r + {{(CHW-1){1'b0}}, 1'b1};
    end
  end

  // Sample pipeline: address, LUT read, quadrant sign, output; outputs only load valid data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_r    <= 1'b0;
      s2_v_r    <= 1'b0;
      s3_v_r    <= 1'b0;
      s1_ch_r   <= '0;
      s2_ch_r   <= '0;
      s3_ch_r   <= '0;
      s1_quad_r <= 2'd0;
      s2_quad_r <= 2'd0;
      s1_addr_r <= '0;
      s2_ls_r   <= '0;
      s2_lc_r   <= '0;
      s3_sin_r  <= '0;
      s3_cos_r  <= '0;
      fsin_o    <= '0;
      fcos_o    <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clken) begin
        s1_v_r    <= 1'b1;
        s1_ch_r   <= ch_cnt_r;
        s1_quad_r <= p_hi_s[HW-1 -: 2];
        s1_addr_r <= addr_s;
        s2_v_r    <= s1_v_r;
        s2_ch_r   <= s1_ch_r;
        s2_quad_r <= s1_quad_r;
        s2_ls_r   <= lut_s[s1_addr_r];
        s2_lc_r   <= lut_s[~s1_addr_r];
        s3_v_r    <= s2_v_r;
        s3_ch_r   <= s2_ch_r;
        s3_sin_r  <= s2_quad_r[1] ? -ls_ext_s : ls_ext_s;
        s3_cos_r  <= (s2_quad_r[1] ^ s2_quad_r[0]) ? -lc_ext_s : lc_ext_s;
        if (s3_v_r) begin
          fsin_o <= s3_sin_r;
          fcos_o <= s3_cos_r;
          out_ch <= s3_ch_r;
        end
      end
      out_valid <= clken & s3_v_r;
    end
  end

endmodule

// File: tb/tb_nco_tdm_pm.sv
// Directed plus random bench for nco_tdm_pm: a behavioural channel model pushes expected
// samples into a scoreboard on every enabled slot; DUT output pops and compares them.
module tb_nco_tdm_pm;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clken = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_sel = 2'd0;
  logic [1:0] cfg_ch = 2'd0;
  logic [31:0] cfg_data = 32'h0;
  logic signed [13:0] fsin_o, fcos_o;
  logic [1:0] out_ch;
  logic out_valid;

  always #5 clk = ~clk;

  nco_tdm_pm dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .fsin_o(fsin_o), .fcos_o(fcos_o), .out_ch(out_ch), .out_valid(out_valid)
  );

  int checks = 0;
  int failures = 0;

  logic [29:0] sb_q [$];
  logic [29:0] last_exp;
  logic [31:0] m_acc [4];
  logic [31:0] m_inc [4];
  logic [15:0] m_off [4];
  logic [3:0]  m_pend;
  logic [1:0]  m_ch;
  int          en_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  // Ideal sin/cos of the 12-bit quantised phase, sampled at the bin centre.
  function automatic logic [29:0] exp_sample(input logic [1:0] c, input logic [31:0] ph);
    logic [11:0] idx;
    real ang;
    int s, k;
    idx = ph[31:20];
    ang = 2.0 * 3.141592653589793 * (real'(idx) + 0.5) / 4096.0;
    s = rnd(8191.0 * $sin(ang));
    k = rnd(8191.0 * $cos(ang));
    return {c, s[13:0], k[13:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 32'h0;
      m_inc[i] = 32'h0;
      m_off[i] = 16'h0;
    end
    m_pend = 4'h0;
    m_ch = 2'd0;
    en_edges = 0;
    sb_q.delete();
    last_exp = 30'h0;
  endtask

  task automatic tick();
    logic ready_pre, exp_valid;
    logic [1:0] c;
    logic [31:0] ph;
    logic [29:0] e;
    @(posedge clk);
    ready_pre = (m_pend == 4'h0);
    if (clken) begin
      en_edges++;
      c = m_ch;
      ph = m_pend[c] ? 32'h0 : m_acc[c];
      sb_q.push_back(exp_sample(c, ph + {m_off[c], 16'h0}));
      m_acc[c] = m_pend[c] ? m_inc[c] : m_acc[c] + m_inc[c];
      m_pend[c] = 1'b0;
      m_ch = m_ch + 2'd1;
    end
    if (cfg_valid && ready_pre) begin
      case (cfg_sel)
        2'd0: m_inc[cfg_ch] = cfg_data;
        2'd1: m_off[cfg_ch] = cfg_data[15:0];
        2'd2: m_pend[cfg_ch] = 1'b1;
        default: ;
      endcase
    end
    exp_valid = clken && (en_edges >= 4);
    #1;
    chk("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
    chk("cfg_ready", {31'h0, cfg_ready}, {31'h0, (m_pend == 4'h0)});
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=valid expected=no_sample");
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        chk("sample", {2'b00, out_ch, fsin_o, fcos_o}, {2'b00, e});
      end
    end else begin
      chk("hold", {2'b00, out_ch, fsin_o, fcos_o}, {2'b00, last_exp});
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [1:0] ch, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_sel = sel;
    cfg_ch = ch;
    cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out", {2'b00, out_valid, out_ch, fsin_o, fcos_o}, 32'h0);
    chk("rst_ready", {31'h0, cfg_ready}, 32'h1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    // all channels idle at phase 0, first sample after the 4th edge
    clken = 1'b1;
    run(12);
    // ch0 stepping a quarter turn per slot
    cfg(2'd0, 2'd0, 32'h40000000);
    run(16);
    // ch1 phase offsets
    cfg(2'd1, 2'd1, 32'h00004000);
    run(8);
    cfg(2'd1, 2'd1, 32'h00008000);
    run(8);
    // ch2 running, then a sync; a second sync is refused while one is pending
    cfg(2'd0, 2'd2, 32'h10000000);
    run(6);
    cfg(2'd2, 2'd2, 32'h0);
    cfg(2'd2, 2'd0, 32'h0);
    run(12);
    cfg(2'd3, 2'd1, 32'hFFFFFFFF);
    run(4);
    // sparse clock enable
    for (int i = 0; i < 30; i++) begin
      clken = ((i % 3) == 0);
      tick();
    end
    clken = 1'b1;
    run(6);
    // random config traffic and enable gaps
    for (int i = 0; i < 80; i++) begin
      clken = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_data = $urandom;
      tick();
    end
    cfg_valid = 1'b0;
    clken = 1'b1;
    run(6);
    // asynchronous reset mid-stream, then restart
    do_reset();
    clken = 1'b1;
    run(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
